// File: rtl/midi_msg_scheduler_if.sv
// Byte stream from the MIDI message scheduler to the UART transmitter.
// The scheduler is the master: it presents byte_out/byte_valid and the
// transmitter answers with byte_ready in the cycle it takes the byte.
interface midi_msg_scheduler_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/midi_msg_scheduler.sv
// MIDI message scheduler: turns a debounced key bitmap into note-on and
// note-off messages, plus program-change requests, and streams the bytes
// out one at a time over a valid/ready handshake.
// The program number input is named prog_num because "program" is a
// reserved word in SystemVerilog.
module midi_msg_scheduler #(
  parameter int unsigned BASE_NOTE = 60,
  parameter logic [3:0]  CHANNEL   = 4'd0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [9:0]                  key,
  input  logic [4:0]                  pitchshift,
  input  logic [7:0]                  volume,
  input  logic                        prog_req,
  input  logic [6:0]                  prog_num,
  output logic                        prog_ack,
  midi_msg_scheduler_if.master        tx,
  output logic                        busy,
  output logic [15:0]                 msg_cnt
);

  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;
  typedef enum logic [1:0] {K_PROG, K_ON, K_OFF} kind_t;

  state_t      state;
  kind_t       kind;
  logic [3:0]  idx;
  logic [7:0]  byte1;
  logic [7:0]  byte2;
  logic [7:0]  out_q;
  logic        valid_q;
  logic [9:0]  sounding;
  logic [7:0]  num [10];

  logic [9:0]  desired;
  logic [9:0]  pend_off;
  logic [9:0]  pend_on;
  logic        off_any;
  logic        on_any;
  logic [3:0]  off_idx;
  logic [3:0]  on_idx;
  logic [9:0]  note_sum;
  logic [7:0]  note_on;
  logic [7:0]  velocity;

  assign tx.byte_out   = out_q;
  assign tx.byte_valid = valid_q;

  assign desired  = ena ? key : 10'b0;
  assign pend_off = sounding & ~desired;
  assign pend_on  = desired & ~sounding;

  // Lowest-index pending note-off and note-on, found fresh every cycle.
  always_comb begin
    off_any = 1'b0;
    on_any  = 1'b0;
    off_idx = 4'd0;
    on_idx  = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (pend_off[i]) begin
        off_any = 1'b1;
        off_idx = 4'(i);
      end
      if (pend_on[i]) begin
        on_any = 1'b1;
        on_idx = 4'(i);
      end
    end
  end

  // Note number and velocity for a candidate note-on, saturated to the MIDI range.
  always_comb begin
    note_sum = 10'(BASE_NOTE) + 10'(pitchshift) + 10'(on_idx);
    note_on  = (note_sum > 10'd127) ? 8'd127 : {1'b0, note_sum[6:0]};
    velocity = (volume[7:1] == 7'd0) ? 8'd1 : {1'b0, volume[7:1]};
  end

  // Scheduler: pick and latch a message in IDLE, then hand out its bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      kind     <= K_PROG;
      idx      <= 4'd0;
      byte1    <= 8'd0;
      byte2    <= 8'd0;
      out_q    <= 8'd0;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      prog_ack <= 1'b0;
      msg_cnt  <= 16'd0;
      sounding <= 10'd0;
      for (int i = 0; i < 10; i++) num[i] <= 8'd0;
    end else begin
      prog_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (prog_req) begin
            kind    <= K_PROG;
            out_q   <= {4'hC, CHANNEL};
            byte1   <= {1'b0, prog_num};
            byte2   <= 8'd0;
            valid_q <= 1'b1;
            busy    <= 1'b1;
            state   <= B0;
          end else if (off_any) begin
            kind    <= K_OFF;
            idx     <= off_idx;
            out_q   <= {4'h8, CHANNEL};
            byte1   <= num[off_idx];
            byte2   <= 8'h40;
            valid_q <= 1'b1;
            busy    <= 1'b1;
            state   <= B0;
          end else if (on_any) begin
            kind        <= K_ON;
            idx         <= on_idx;
            out_q       <= {4'h9, CHANNEL};
            byte1       <= note_on;
            byte2       <= velocity;
            num[on_idx] <= note_on;
            valid_q     <= 1'b1;
            busy        <= 1'b1;
            state       <= B0;
          end
        end
        B0: begin
          if (tx.byte_ready) begin
            out_q <= byte1;
            state <= B1;
          end
        end
        B1: begin
          if (tx.byte_ready) begin
            if (kind == K_PROG) begin
              out_q    <= 8'd0;
              valid_q  <= 1'b0;
              busy     <= 1'b0;
              prog_ack <= 1'b1;
              msg_cnt  <= msg_cnt + 16'd1;
              state    <= IDLE;
            end else begin
              out_q <= byte2;
              state <= B2;
            end
          end
        end
        B2: begin
          if (tx.byte_ready) begin
            out_q   <= 8'd0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            msg_cnt <= msg_cnt + 16'd1;
            if (kind == K_ON) sounding[idx] <= 1'b1;
            else              sounding[idx] <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
